// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide sequencer and its datapath core.
package mdu_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ITER   = 32;
  localparam int unsigned CNT_W  = 6;

  typedef enum logic [2:0] {
    IDLE,
    MULT_RUN,
    DIV_RUN,
    FINISH,
    DIV0_ERR
  } state_t;

endpackage

// File: rtl/mdu_core.sv
// Iterative signed multiply / restoring divide datapath.
// Works on operand magnitudes; signs are re-applied as the result is committed.
module mdu_core #(
  parameter int unsigned DATA_W = mdu_pkg::DATA_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load,
  input  logic              i_div,
  input  logic              i_step,
  input  logic              i_commit,
  input  logic [DATA_W-1:0] i_op_a,
  input  logic [DATA_W-1:0] i_op_b,
  output logic [DATA_W-1:0] o_hi,
  output logic [DATA_W-1:0] o_lo
);

  // r_acc: running upper product / partial remainder
  // r_q:   multiplier being consumed / dividend shifting out, quotient shifting in
  logic [DATA_W-1:0] r_acc;
  logic [DATA_W-1:0] r_q;
  logic [DATA_W-1:0] r_m;
  logic              r_neg_a;
  logic              r_neg_b;
  logic              r_div;
  logic [DATA_W-1:0] r_hi;
  logic [DATA_W-1:0] r_lo;

  logic [DATA_W-1:0]     w_mag_a;
  logic [DATA_W-1:0]     w_mag_b;
  logic [DATA_W:0]       w_sum;
  logic [DATA_W:0]       w_addend;
  logic [DATA_W:0]       w_shift;
  logic [DATA_W+1:0]     w_diff;
  logic [DATA_W-1:0]     w_acc_next;
  logic [DATA_W-1:0]     w_q_next;
  logic [2*DATA_W-1:0]   w_prod;
  logic [DATA_W-1:0]     w_quot;
  logic [DATA_W-1:0]     w_rem;

  // Magnitudes: the most negative value maps to its unsigned magnitude.
  always_comb begin
    w_mag_a = i_op_a[DATA_W-1] ? -i_op_a : i_op_a;
    w_mag_b = i_op_b[DATA_W-1] ? -i_op_b : i_op_b;
  end

  // One iteration of the selected algorithm, plus the sign-corrected result of that iteration.
  always_comb begin
    w_sum      = {1'b0, r_acc} + {1'b0, r_m};
    w_addend   = r_q[0] ? w_sum : {1'b0, r_acc};
    w_shift    = {r_acc, r_q[DATA_W-1]};
    w_diff     = {1'b0, w_shift} - {2'b00, r_m};
    w_acc_next = '0;
    w_q_next   = '0;
    if (r_div) begin
      if (!w_diff[DATA_W+1]) begin
        w_acc_next = w_diff[DATA_W-1:0];
        w_q_next   = {r_q[DATA_W-2:0], 1'b1};
      end else begin
        w_acc_next = w_shift[DATA_W-1:0];
        w_q_next   = {r_q[DATA_W-2:0], 1'b0};
      end
    end else begin
      w_acc_next = w_addend[DATA_W:1];
      w_q_next   = {w_addend[0], r_q[DATA_W-1:1]};
    end
    w_prod = (r_neg_a ^ r_neg_b) ? -{w_acc_next, w_q_next} : {w_acc_next, w_q_next};
    w_quot = (r_neg_a ^ r_neg_b) ? -w_q_next : w_q_next;
    w_rem  = r_neg_a ? -w_acc_next : w_acc_next;
  end

  // Working registers: loaded on an accepted start, advanced once per step.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_acc   <= '0;
      r_q     <= '0;
      r_m     <= '0;
      r_neg_a <= 1'b0;
      r_neg_b <= 1'b0;
      r_div   <= 1'b0;
    end else if (i_load) begin
      r_acc   <= '0;
      r_q     <= w_mag_a;
      r_m     <= w_mag_b;
      r_neg_a <= i_op_a[DATA_W-1];
      r_neg_b <= i_op_b[DATA_W-1];
      r_div   <= i_div;
    end else if (i_step) begin
      r_acc <= w_acc_next;
      r_q   <= w_q_next;
    end
  end

  // Result registers: written only on the final step, otherwise hold.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (i_step && i_commit) begin
      if (r_div) begin
        r_hi <= w_rem;
        r_lo <= w_quot;
      end else begin
        r_hi <= w_prod[2*DATA_W-1:DATA_W];
        r_lo <= w_prod[DATA_W-1:0];
      end
    end
  end

  assign o_hi = r_hi;
  assign o_lo = r_lo;

endmodule

// File: rtl/mult_div_sequencer.sv
// Control sequencer for the multicycle CPU's signed MULT/DIV unit.
// Accepts one-cycle starts, runs the iterative core, and pulses done/hilo_write or div0.
module mult_div_sequencer #(
  parameter int unsigned DATA_W = mdu_pkg::DATA_W,
  parameter int unsigned ITER   = mdu_pkg::ITER
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              mult_start,
  input  logic              div_start,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic              busy,
  output logic              done,
  output logic              hilo_write,
  output logic [DATA_W-1:0] hi_out,
  output logic [DATA_W-1:0] lo_out,
  output logic              div0
);

  import mdu_pkg::*;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;
  logic             r_hilo_write;
  logic             r_div0;

  logic w_idle;
  logic w_run;
  logic w_last;
  logic w_div_ok;
  logic w_load;

  // Core control derived from the current state; mult_start has priority over div_start.
  always_comb begin
    w_idle   = (r_state == IDLE);
    w_run    = (r_state == MULT_RUN) || (r_state == DIV_RUN);
    w_last   = (r_cnt == CNT_W'(ITER - 1));
    w_div_ok = div_start && (op_b != '0);
    w_load   = w_idle && (mult_start || w_div_ok);
  end

  // Sequencer FSM with registered status outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_hilo_write <= 1'b0;
      r_div0       <= 1'b0;
    end else begin
      r_done       <= 1'b0;
      r_hilo_write <= 1'b0;
      r_div0       <= 1'b0;
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (mult_start) begin
            r_state <= MULT_RUN;
            r_busy  <= 1'b1;
          end else if (w_div_ok) begin
            r_state <= DIV_RUN;
            r_busy  <= 1'b1;
          end else if (div_start) begin
            r_state <= DIV0_ERR;
            r_div0  <= 1'b1;
            r_done  <= 1'b1;
          end
        end
        MULT_RUN, DIV_RUN: begin
          if (w_last) begin
            r_state      <= FINISH;
            r_cnt        <= '0;
            r_done       <= 1'b1;
            r_hilo_write <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        FINISH: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        DIV0_ERR: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  mdu_core #(
    .DATA_W (DATA_W)
  ) u_core (
    .i_clk    (clock),
    .i_rst    (reset),
    .i_load   (w_load),
    .i_div    (!mult_start),
    .i_step   (w_run),
    .i_commit (w_last),
    .i_op_a   (op_a),
    .i_op_b   (op_b),
    .o_hi     (hi_out),
    .o_lo     (lo_out)
  );

  assign busy       = r_busy;
  assign done       = r_done;
  assign hilo_write = r_hilo_write;
  assign div0       = r_div0;

endmodule

// File: doc/mult_div_sequencer.md
Name: mult_div_sequencer

Overview:
- Sequences the multicycle CPU's signed MULT/DIV resource.
- Accepts a one-cycle start from the main control unit and latches operands from the A/B registers.
- Runs a 32-iteration shift-add (MULT) or restoring shift-subtract (DIV) core, then writes HI/LO.
- Holds busy so the main control FSM waits, and raises a div-by-zero exception pulse toward the EPC/exception path.

Parameters:
- DATA_W, 32, operand and HI/LO width.
- ITER, 32, iteration count; must equal DATA_W.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- mult_start  in  1  one-cycle request: signed multiply op_a*op_b.
- div_start  in  1  one-cycle request: signed divide op_a/op_b.
- op_a  in  DATA_W  rs value (multiplicand / dividend), sampled only on an accepted start.
- op_b  in  DATA_W  rt value (multiplier / divisor), sampled only on an accepted start.
- busy  out  1  high while an operation is in progress (RUN and FINISH states).
- done  out  1  one-cycle pulse: operation complete.
- hilo_write  out  1  one-cycle pulse coincident with done on success; HILO register enable.
- hi_out  out  DATA_W  MULT: upper product. DIV: remainder.
- lo_out  out  DATA_W  MULT: lower product. DIV: quotient.
- div0  out  1  one-cycle exception pulse: divisor was zero.

Behaviour:
- Interface decision: one clock (clock); reset is asynchronous and active-high (reset).
- Reset values: state IDLE; busy, done, hilo_write, div0 = 0; hi_out, lo_out = 0; iteration counter = 0.
- State IDLE:
  - mult_start=1 -> latch operands, go to MULT_RUN.
  - div_start=1 and op_b!=0 -> latch operands, go to DIV_RUN.
  - div_start=1 and op_b==0 -> go to DIV0_ERR.
  - Both starts high: mult_start wins; div_start is dropped.
- State MULT_RUN / DIV_RUN:
  - Exactly ITER cycles, counter 0..ITER-1; on the last count go to FINISH.
  - The core operates on operand magnitudes.
  - Sign-corrected result is registered into hi_out/lo_out on the edge entering FINISH.
- State FINISH:
  - done=1, hilo_write=1, busy=1 for one cycle; then IDLE.
  - New hi_out/lo_out are visible in this same cycle.
- State DIV0_ERR:
  - div0=1 for one cycle; done=1; hilo_write=0; busy=0.
  - hi_out/lo_out hold their previous values; then IDLE.
- Latency: start accepted at edge N -> busy from N+1 -> FINISH cycle is N+33 -> idle at N+34; earliest next start accepted at edge N+34. DIV0 pulse occurs in cycle N+1.
- Arithmetic:
  - MULT: 64-bit two's-complement product; negate if sign(a)!=sign(b).
  - DIV: quotient truncates toward zero; remainder takes the sign of the dividend; |rem| < |divisor|.
  - 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0; no exception, no overflow flag.
  - Magnitude of 0x80000000 is computed as an unsigned 0x80000000, which is correct in DATA_W+1-bit internal arithmetic.
- Start while busy (any state other than IDLE): ignored; operands are not re-sampled; no queueing.
- Reset mid-operation: immediate return to IDLE; outputs to reset values; no done or hilo_write pulse.
- hi_out/lo_out hold between operations; they change only on the FINISH entry edge or on reset.

Decomposition:
- Shared package mdu_pkg:
  - State encoding typedef: IDLE, MULT_RUN, DIV_RUN, FINISH, DIV0_ERR.
  - DATA_W and ITER constants.
  - Counter width constant CNT_W = 6.
- One sub-module, mdu_core:
  - Magnitude registers; one shift-add or shift-subtract step per enable.
  - Final sign correction.
  - Driven by the sequencer FSM through load, step, and mode inputs.

Test Plan:
- mult_start, a=7, b=0xFFFFFFFD (-3) -> busy for 33 cycles; FINISH cycle shows hi=0xFFFFFFFF, lo=0xFFFFFFEB, done=hilo_write=1.
- div_start, a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1), done after 33 cycles.
- div_start, a=5, b=0 -> div0=1 and done=1 in next cycle, hilo_write=0, hi/lo unchanged from the prior op, busy never high.
- div_start, a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0, div0=0; mult a=0x80000000, b=0x80000000 -> hi=0x40000000, lo=0.
- mult 3*4 started, then div_start pulsed at cycle 10 of RUN -> ignored; result hi=0, lo=12 at cycle 33; same cycle mult_start+div_start from IDLE -> multiply executed.
- reset asserted asynchronously mid-DIV_RUN (cycle 15) -> busy/done/hilo_write drop immediately, hi/lo=0, no later done pulse; a subsequent mult completes normally.
